// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
// The optional statistics counters in dcache_ctrl are enabled with the DCACHE_STATS_EN macro.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WTHRU = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WORD_W      = 32;
  localparam int DEF_INDEX_W = 5;
  localparam int DEF_WORDS   = 4;
  localparam int DEF_ADDR_W  = 32;

  localparam int OFFSET_W = $clog2(DEF_WORDS);
  localparam int TAG_W    = DEF_ADDR_W - DEF_INDEX_W - OFFSET_W - 2;
  localparam int BLK_W    = WORD_W * DEF_WORDS;

  function automatic int calc_offset_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int index_w, input int words);
    return addr_w - index_w - $clog2(words) - 2;
  endfunction

  // Byte address is laid out as {tag, index, word offset, 2'b byte}.
  function automatic logic [63:0] addr_offset(input logic [63:0] a, input int off_w);
    return (a >> 2) & ((64'd1 << off_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_index(input logic [63:0] a, input int off_w,
                                             input int index_w);
    return (a >> (2 + off_w)) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w,
                                           input int index_w);
    return a >> (2 + off_w + index_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped cache: combinational read, block fill,
// single-word update on a write-through hit, and asynchronous clear of all valid bits.
module dcache_array #(
  parameter int INDEX_W  = 5,
  parameter int TAG_W    = 23,
  parameter int OFFSET_W = 2,
  parameter int BLK_W    = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  i_index,
  output logic                o_valid,
  output logic [TAG_W-1:0]    o_tag,
  output logic [BLK_W-1:0]    o_block,
  input  logic                i_blk_we,
  input  logic [TAG_W-1:0]    i_blk_tag,
  input  logic [BLK_W-1:0]    i_blk_data,
  input  logic                i_word_we,
  input  logic [OFFSET_W-1:0] i_word_off,
  input  logic [31:0]         i_word_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [BLK_W-1:0] r_data [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_blk_we) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Tag and data contents are don't-care until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (i_blk_we) begin
      r_tag[i_index]  <= i_blk_tag;
      r_data[i_index] <= i_blk_data;
    end else if (i_word_we) begin
      r_data[i_index][{i_word_off, 5'd0} +: 32] <= i_word_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss/write counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W       = 5,
  parameter int WORDS_PER_BLK = 4,
  parameter int ADDR_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      stall,
  output logic                      mem_rd_req,
  output logic                      mem_wr_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [32*WORDS_PER_BLK-1:0] mem_rdata,
  input  logic                      mem_ack,
  output state_t                    dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt,
  output logic [31:0]               wr_cnt
`endif
);

  localparam int OFF_W   = calc_offset_w(WORDS_PER_BLK);
  localparam int TAG_LEN = calc_tag_w(ADDR_W, INDEX_W, WORDS_PER_BLK);
  localparam int BLK_LEN = 32 * WORDS_PER_BLK;

  localparam logic [ADDR_W-1:0] BLK_MASK  = ~((ADDR_W'(1) << (OFF_W + 2)) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            r_state;
  logic              r_mem_rd_req;
  logic              r_mem_wr_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [ADDR_W-1:0]  w_sel_addr;
  logic [OFF_W-1:0]   w_off;
  logic [INDEX_W-1:0] w_idx;
  logic [TAG_LEN-1:0] w_tag;
  logic               w_line_valid;
  logic [TAG_LEN-1:0] w_line_tag;
  logic [BLK_LEN-1:0] w_line_block;
  logic [31:0]        w_line_word;
  logic               w_hit;
  logic               w_rd_hit;
  logic               w_go_fill;
  logic               w_go_wthru;
  logic               w_fill_we;
  logic               w_word_we;
  logic               w_stall;

  // In IDLE the lookup follows the live core address; while a memory transaction is
  // outstanding it follows the captured address so the ack-cycle update hits the right line.
  assign w_sel_addr = (r_state == ST_IDLE) ? addr : r_mem_addr;
  assign w_off      = OFF_W'(addr_offset(64'(w_sel_addr), OFF_W));
  assign w_idx      = INDEX_W'(addr_index(64'(w_sel_addr), OFF_W, INDEX_W));
  assign w_tag      = TAG_LEN'(addr_tag(64'(w_sel_addr), OFF_W, INDEX_W));

  dcache_array #(
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_LEN),
    .OFFSET_W (OFF_W),
    .BLK_W    (BLK_LEN)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_idx),
    .o_valid     (w_line_valid),
    .o_tag       (w_line_tag),
    .o_block     (w_line_block),
    .i_blk_we    (w_fill_we),
    .i_blk_tag   (w_tag),
    .i_blk_data  (mem_rdata),
    .i_word_we   (w_word_we),
    .i_word_off  (w_off),
    .i_word_data (r_mem_wdata)
  );

  assign w_line_word = w_line_block[{w_off, 5'd0} +: 32];
  assign w_hit       = w_line_valid && (w_line_tag == w_tag);

  assign w_go_wthru = (r_state == ST_IDLE) && MemWrite;
  assign w_go_fill  = (r_state == ST_IDLE) && !MemWrite && MemRead && !w_hit;
  assign w_rd_hit   = (r_state == ST_IDLE) && !MemWrite && MemRead && w_hit;
  assign w_fill_we  = (r_state == ST_FILL) && mem_ack;
  assign w_word_we  = (r_state == ST_WTHRU) && mem_ack && w_hit;

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:  w_stall = w_go_wthru || w_go_fill;
      ST_FILL:  w_stall = 1'b1;
      ST_WTHRU: w_stall = 1'b1;
      default:  w_stall = 1'b0;
    endcase
    if (rst) begin
      w_stall = 1'b0;
    end
  end

  // Memory handshake: a request is raised the cycle after the miss/store is seen and is
  // held, together with mem_addr/mem_wdata, until the single-cycle mem_ack completes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go_wthru) begin
            r_state      <= ST_WTHRU;
            r_mem_wr_req <= 1'b1;
            r_mem_addr   <= addr & WORD_MASK;
            r_mem_wdata  <= wdata;
          end else if (w_go_fill) begin
            r_state      <= ST_FILL;
            r_mem_rd_req <= 1'b1;
            r_mem_addr   <= addr & BLK_MASK;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            r_state      <= ST_IDLE;
            r_mem_rd_req <= 1'b0;
          end
        end
        ST_WTHRU: begin
          if (mem_ack) begin
            r_state      <= ST_DONE;
            r_mem_wr_req <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata      = w_rd_hit ? w_line_word : 32'd0;
  assign stall      = w_stall;
  assign mem_rd_req = r_mem_rd_req;
  assign mem_wr_req = r_mem_wr_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign dbg_state  = r_state;

`ifdef DCACHE_STATS_EN
  logic        r_post_fill;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wr_cnt;

  // The hit that retires a just-filled load is already counted as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_post_fill <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_post_fill <= w_fill_we;
      if (w_rd_hit && !r_post_fill && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_go_fill && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      if (w_go_wthru && (r_wr_cnt != 32'hFFFF_FFFF)) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wr_cnt   = r_wr_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs change 2 time units after each rising edge,
// outputs are sampled 1 time unit later.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         MemRead;
  logic         MemWrite;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_rd_req;
  logic         mem_wr_req;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  state_t       dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wr_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .dbg_state  (dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    n_checks++;
    assert (dbg_state === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Read miss at a, ack on the wait_cycles-th FILL cycle; returns in the following hit cycle.
  task automatic do_fill(input logic [31:0] a, input logic [127:0] blk, input int wait_cycles);
    int ns;
    int nr;
    tick();
    MemRead = 1'b1; MemWrite = 1'b0; addr = a; mem_ack = 1'b0;
    settle();
    chk1("fill_detect_stall", stall, 1'b1);
    chk1("fill_detect_no_req", mem_rd_req, 1'b0);
    ns = 1;
    nr = 0;
    for (int c = 0; c < wait_cycles; c++) begin
      tick();
      if (c == wait_cycles - 1) begin
        mem_rdata = blk;
        mem_ack   = 1'b1;
      end
      settle();
      if (stall) ns++;
      if (mem_rd_req) nr++;
      if (c == 0) begin
        chk32("fill_mem_addr", mem_addr, a & 32'hFFFF_FFF0);
        chk_state("fill_state", ST_FILL);
        chk1("fill_no_wr_req", mem_wr_req, 1'b0);
      end
    end
    tick();
    mem_ack = 1'b0;
    mem_rdata = '0;
    settle();
    chk1("fill_hit_unstalled", stall, 1'b0);
    chk1("fill_req_dropped", mem_rd_req, 1'b0);
    chk32("fill_stall_cycles", ns, wait_cycles + 1);
    chk32("fill_req_cycles", nr, wait_cycles);
  endtask

  // Store at a, ack on the wait_cycles-th WTHRU cycle; returns in the DONE cycle.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int wait_cycles,
                          input logic also_read);
    tick();
    MemWrite = 1'b1; MemRead = also_read; addr = a; wdata = d; mem_ack = 1'b0;
    settle();
    chk1("store_detect_stall", stall, 1'b1);
    chk32("store_detect_rdata", rdata, 32'd0);
    for (int c = 0; c < wait_cycles; c++) begin
      tick();
      if (c == wait_cycles - 1) mem_ack = 1'b1;
      settle();
      chk1("store_wthru_stall", stall, 1'b1);
      if (c == 0) begin
        chk_state("store_state", ST_WTHRU);
        chk1("store_wr_req", mem_wr_req, 1'b1);
        chk1("store_no_rd_req", mem_rd_req, 1'b0);
        chk32("store_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        chk32("store_mem_wdata", mem_wdata, d);
      end
    end
    tick();
    mem_ack = 1'b0;
    settle();
    chk_state("store_done_state", ST_DONE);
    chk1("store_done_unstalled", stall, 1'b0);
    chk1("store_done_req_dropped", mem_wr_req, 1'b0);
  endtask

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick();
    settle();
    chk_state("reset_state", ST_IDLE);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_rd_req", mem_rd_req, 1'b0);
    chk1("reset_wr_req", mem_wr_req, 1'b0);
    chk32("reset_mem_addr", mem_addr, 32'd0);
    chk32("reset_mem_wdata", mem_wdata, 32'd0);
    chk32("reset_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;

    // Cold read of 0x40: three FILL cycles, four stalled cycles, then word 0 hits.
    do_fill(32'h0000_0040, {32'd4, 32'd3, 32'd2, 32'd1}, 3);
    chk32("cold_hit_rdata", rdata, 32'd1);

    tick();
    MemRead = 1'b1; addr = 32'h0000_0048;
    settle();
    chk1("hit48_stall", stall, 1'b0);
    chk32("hit48_rdata", rdata, 32'd3);
    chk1("hit48_no_req", mem_rd_req, 1'b0);

    do_store(32'h0000_0044, 32'hDEAD_BEEF, 2, 1'b0);
    tick();
    MemWrite = 1'b0; MemRead = 1'b1; addr = 32'h0000_0044;
    settle();
    chk_state("after_done_idle", ST_IDLE);
    chk1("hit44_stall", stall, 1'b0);
    chk32("hit44_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    addr = 32'h0000_0040;
    settle();
    chk32("hit40_rdata", rdata, 32'd1);

    // Store miss with both strobes high: write wins, line 0 is not allocated.
    do_store(32'h0000_1000, 32'h1234_5678, 1, 1'b1);
    do_fill(32'h0000_1000, {32'h4, 32'h3, 32'h2, 32'hCAFE_0000}, 1);
    chk32("miss1000_rdata", rdata, 32'hCAFE_0000);

    // Same index, different tag: evicts 0x40's line.
    do_fill(32'h0000_0240, {32'd8, 32'd7, 32'd6, 32'd5}, 2);
    chk32("conflict_rdata", rdata, 32'd5);
    do_fill(32'h0000_0040, {32'd4, 32'd3, 32'd2, 32'd1}, 1);
    chk32("reread40_rdata", rdata, 32'd1);
    tick();
    addr = 32'h0000_0244;
    settle();
    chk1("evicted240_stall", stall, 1'b1);
    MemRead = 1'b0;

    // Reset in the middle of a fill of 0x80.
    tick();
    MemRead = 1'b1; addr = 32'h0000_0080;
    settle();
    chk1("rstfill_detect_stall", stall, 1'b1);
    tick();
    settle();
    chk1("rstfill_req_up", mem_rd_req, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk1("rstfill_req_drop", mem_rd_req, 1'b0);
    chk1("rstfill_stall_drop", stall, 1'b0);
    chk_state("rstfill_state", ST_IDLE);
    tick();
    rst = 1'b0; MemRead = 1'b0; mem_rdata = {4{32'h5555_AAAA}}; mem_ack = 1'b1;
    settle();
    chk1("late_ack_no_req", mem_rd_req, 1'b0);
    tick();
    mem_ack = 1'b0; MemRead = 1'b1; addr = 32'h0000_0080;
    settle();
    chk_state("late_ack_ignored", ST_IDLE);
    chk1("late_ack_no_alloc", stall, 1'b1);
    chk32("late_ack_rdata", rdata, 32'd0);
    addr = 32'h0000_0040;
    #1;
    chk1("valid_cleared_40", stall, 1'b1);
    tick();
    MemRead = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
